control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock (input, 1, rising-edge clock) and clear (input, 1, asynchronous active-low reset).
REQ-002 The block SHALL have these inputs: ir (32, instruction register contents, opcode ir[31:27]) and con_ff (1, branch-condition flag).
REQ-003 The block SHALL have these register-file select outputs: Gra, Grb, Grc, Rin, Rout, BAout (1 each, to register select/encode logic).
REQ-004 The block SHALL have these register and bus outputs: PCin, IRin, Yin, HIin, LOin, MARin, MDRin, ZHIin, ZLOin, CONin (1 each, register load enables); PCout, MDRout, ZHighout, Zlowout, HIout, LOout, Cout (1 each, bus drivers).
REQ-005 The block SHALL have these memory and ALU outputs: Read, Write, IncPC (1 each); alu_op (5, ALU operation code); run (1, high while executing).

Function
REQ-006 Encoding: ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=01001, or=01010, addi=01011, andi=01100, ori=01101, mul=01110, div=01111, neg=10000, not=10001, br=10010, mfhi=10111, mflo=11000, nop=11001, halt=11010.
REQ-007 The block SHALL treat all other opcodes as nop.
REQ-008 States SHALL be RST, T0..T7 and HALT, with the datapath advancing one step per clock.
REQ-009 All outputs SHALL be a combinational decode of state and ir[31:27] (Moore per state); outputs not listed for a step SHALL be 0.
REQ-010 Fetch: T0 = PCout, MARin, IncPC, ZLOin; T1 = Zlowout, PCin, Read, MDRin; T2 = MDRout, IRin.
REQ-011 Register-register ops (add, sub, and, or): T3 = Grb, Rout, Yin; T4 = Grc, Rout, ZLOin, alu_op=opcode; T5 = Zlowout, Gra, Rin; then T0.
REQ-012 Immediate ops (addi, andi, ori): same as REQ-011, except T4 drives Cout instead of Grc/Rout.
REQ-013 ld: T3 = Grb, BAout, Yin; T4 = Cout, ZLOin, alu_op=add; T5 = Zlowout, MARin; T6 = Read, MDRin; T7 = MDRout, Gra, Rin; then T0.
REQ-014 ldi: T3 and T4 as ld; T5 = Zlowout, Gra, Rin; then T0.
REQ-015 st: T3 through T5 as ld; T6 = Gra, Rout, MDRin (Read=0, bus source); T7 = Write; then T0.
REQ-016 mul/div: T3 = Gra, Rout, Yin; T4 = Grb, Rout, alu_op, ZLOin, ZHIin; T5 = Zlowout, LOin; T6 = ZHighout, HIin; then T0.
REQ-017 neg/not: T3 = Grb, Rout, alu_op, ZLOin; T4 = Zlowout, Gra, Rin; then T0.
REQ-018 br: T3 = Gra, Rout, CONin; T4 = PCout, Yin; T5 = Cout, alu_op=add, ZLOin; T6 = Zlowout, with PCin = con_ff sampled in T6; then T0.
REQ-019 mfhi/mflo: T3 = HIout (or LOout), Gra, Rin; then T0.
REQ-020 nop: T2 SHALL transition directly to T0.
REQ-021 halt: T2 SHALL transition to HALT; HALT SHALL drive all outputs 0 and run=0, and SHALL be left only by reset.
REQ-022 Latency: each instruction SHALL take exactly 3 + its execute steps in cycles (add = 6, ld = 8, nop = 3).
REQ-023 ir SHALL be read only in T3..T7; a change to ir during T0..T2 SHALL have no effect.
REQ-024 run SHALL be 1 in all states except RST and HALT.

Reset
REQ-025 clear=0 SHALL force state RST immediately (asynchronously), at any point including mid-instruction, with all outputs 0 and run=0.
REQ-026 The first rising clock edge with clear=1 SHALL move RST to T0.
REQ-027 No partial register load or Write SHALL be issued after clear falls.

Structure
REQ-028 Opcode localparams, state encoding and alu_op values SHALL live in a shared package cpu_defs, used by the ALU as well.
REQ-029 One sub-module, opcode_decoder, SHALL map ir[31:27] to an instruction-class one-hot; the FSM and output decode SHALL remain in control_sequencer.

Verification
REQ-030 Reset then ir=0x18918000 (add R1,R2,R3): Gra, Rin and Zlowout SHALL be high in cycle 6 after T0; the sequence SHALL then return to T0.
REQ-031 ld opcode: Read SHALL be high in T1 and T6, MDRout/Gra/Rin in T7, and the next T0 SHALL occur 8 cycles after the previous one.
REQ-032 br with con_ff=1 SHALL give PCin=1 in T6; with con_ff=0, PCin SHALL stay 0 throughout T3..T6.
REQ-033 ir=0xD0000000 (halt): after T2, state SHALL be HALT with run=0 and all outputs 0 for 20 cycles; a clear pulse SHALL restart at T0.
REQ-034 clear asserted mid-st in T6: Write SHALL never assert, outputs SHALL go 0 within the same cycle, and the block SHALL re-enter T0 after release.
REQ-035 An undefined opcode (11111) SHALL behave as nop: 3-cycle loop with no Rin or Write.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared CPU definitions: opcodes, ALU operation codes, control-step
// encoding and the instruction-class one-hot layout. Used by the control
// sequencer and the ALU so that both agree on every code.
package cpu_defs;

    // Opcodes carried in ir[31:27]
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    // ALU operation codes: the ALU decodes the same values as the opcodes,
    // so arithmetic steps simply forward the opcode. Address and branch
    // target computations always use ALU_ADD.
    localparam logic [4:0] ALU_ADD  = OP_ADD;
    localparam logic [4:0] ALU_SUB  = OP_SUB;
    localparam logic [4:0] ALU_AND  = OP_AND;
    localparam logic [4:0] ALU_OR   = OP_OR;
    localparam logic [4:0] ALU_ADDI = OP_ADDI;
    localparam logic [4:0] ALU_ANDI = OP_ANDI;
    localparam logic [4:0] ALU_ORI  = OP_ORI;
    localparam logic [4:0] ALU_MUL  = OP_MUL;
    localparam logic [4:0] ALU_DIV  = OP_DIV;
    localparam logic [4:0] ALU_NEG  = OP_NEG;
    localparam logic [4:0] ALU_NOT  = OP_NOT;

    // Control-step encoding
    localparam logic [3:0] ST_RST  = 4'd0;
    localparam logic [3:0] ST_T0   = 4'd1;
    localparam logic [3:0] ST_T1   = 4'd2;
    localparam logic [3:0] ST_T2   = 4'd3;
    localparam logic [3:0] ST_T3   = 4'd4;
    localparam logic [3:0] ST_T4   = 4'd5;
    localparam logic [3:0] ST_T5   = 4'd6;
    localparam logic [3:0] ST_T6   = 4'd7;
    localparam logic [3:0] ST_T7   = 4'd8;
    localparam logic [3:0] ST_HALT = 4'd9;

    // Instruction-class one-hot bit positions
    localparam int CLS_W      = 12;
    localparam int CLS_LD     = 0;   // ld
    localparam int CLS_LDI    = 1;   // ldi
    localparam int CLS_ST     = 2;   // st
    localparam int CLS_RR     = 3;   // add, sub, and, or
    localparam int CLS_IMM    = 4;   // addi, andi, ori
    localparam int CLS_MULDIV = 5;   // mul, div
    localparam int CLS_UNARY  = 6;   // neg, not
    localparam int CLS_BR     = 7;   // br
    localparam int CLS_MFHI   = 8;   // mfhi
    localparam int CLS_MFLO   = 9;   // mflo
    localparam int CLS_NOP    = 10;  // nop and every undefined opcode
    localparam int CLS_HALT   = 11;  // halt

    typedef logic [CLS_W-1:0] cls_t;

endpackage

// File: rtl/control_sequencer_opcode_decoder.sv
// Opcode decoder: maps the 5-bit opcode onto a one-hot instruction class.
// Any opcode without a defined meaning lands in the nop class.
module opcode_decoder
    import cpu_defs::*;
(
    input  logic [4:0] opcode,
    output cls_t       cls
);

    // One-hot class select; exactly one bit is always set
    always_comb begin
        cls = '0;
        case (opcode)
            OP_LD:                          cls[CLS_LD]     = 1'b1;
            OP_LDI:                         cls[CLS_LDI]    = 1'b1;
            OP_ST:                          cls[CLS_ST]     = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR:  cls[CLS_RR]     = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI:       cls[CLS_IMM]    = 1'b1;
            OP_MUL, OP_DIV:                 cls[CLS_MULDIV] = 1'b1;
            OP_NEG, OP_NOT:                 cls[CLS_UNARY]  = 1'b1;
            OP_BR:                          cls[CLS_BR]     = 1'b1;
            OP_MFHI:                        cls[CLS_MFHI]   = 1'b1;
            OP_MFLO:                        cls[CLS_MFLO]   = 1'b1;
            OP_HALT:                        cls[CLS_HALT]   = 1'b1;
            default:                        cls[CLS_NOP]    = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer. Steps through fetch (T0..T2) and the
// per-class execute steps (T3..T7), producing a Moore decode of the
// current step and opcode. Reset is asynchronous: dropping clear forces
// RST immediately, which drives every control output to 0 in the same
// cycle so no partial register load or memory write can escape.
// state_dbg mirrors the current step for observation.
module control_sequencer
    import cpu_defs::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        MARin,
    output logic        MDRin,
    output logic        ZHIin,
    output logic        ZLOin,
    output logic        CONin,
    output logic        PCout,
    output logic        MDRout,
    output logic        ZHighout,
    output logic        Zlowout,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        Read,
    output logic        Write,
    output logic        IncPC,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic [3:0]  state_dbg
);

    logic [3:0] state;
    logic [3:0] next_state;
    logic [4:0] opcode;
    cls_t       cls;
    logic       unused_ir;

    assign opcode    = ir[31:27];
    assign unused_ir = ^ir[26:0];
    assign state_dbg = state;

    opcode_decoder u_opcode_decoder (
        .opcode (opcode),
        .cls    (cls)
    );

    // Step register; clear overrides everything asynchronously
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= ST_RST;
        end else begin
            state <= next_state;
        end
    end

    // Step sequencing: each class leaves the execute phase after its last step
    always_comb begin
        next_state = ST_RST;
        case (state)
            ST_RST:  next_state = ST_T0;
            ST_T0:   next_state = ST_T1;
            ST_T1:   next_state = ST_T2;
            ST_T2: begin
                if (cls[CLS_HALT])     next_state = ST_HALT;
                else if (cls[CLS_NOP]) next_state = ST_T0;
                else                   next_state = ST_T3;
            end
            ST_T3:   next_state = (cls[CLS_MFHI] || cls[CLS_MFLO]) ? ST_T0 : ST_T4;
            ST_T4:   next_state = cls[CLS_UNARY] ? ST_T0 : ST_T5;
            ST_T5:   next_state = (cls[CLS_RR] || cls[CLS_IMM] || cls[CLS_LDI])
                                  ? ST_T0 : ST_T6;
            ST_T6:   next_state = (cls[CLS_MULDIV] || cls[CLS_BR]) ? ST_T0 : ST_T7;
            ST_T7:   next_state = ST_T0;
            ST_HALT: next_state = ST_HALT;
            default: next_state = ST_RST;
        endcase
    end

    // Control decode of step and class; anything not named stays 0
    always_comb begin
        Gra = 1'b0;  Grb = 1'b0;  Grc = 1'b0;  Rin = 1'b0;  Rout = 1'b0;
        BAout = 1'b0;
        PCin = 1'b0;  IRin = 1'b0;  Yin = 1'b0;  HIin = 1'b0;  LOin = 1'b0;
        MARin = 1'b0; MDRin = 1'b0; ZHIin = 1'b0; ZLOin = 1'b0; CONin = 1'b0;
        PCout = 1'b0; MDRout = 1'b0; ZHighout = 1'b0; Zlowout = 1'b0;
        HIout = 1'b0; LOout = 1'b0; Cout = 1'b0;
        Read = 1'b0;  Write = 1'b0; IncPC = 1'b0;
        alu_op = 5'b00000;
        run = (state != ST_RST) && (state != ST_HALT);
        case (state)
            ST_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLOin = 1'b1;
            end
            ST_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            ST_T3: begin
                if (cls[CLS_RR] || cls[CLS_IMM]) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end
                if (cls[CLS_LD] || cls[CLS_LDI] || cls[CLS_ST]) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end
                if (cls[CLS_MULDIV]) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end
                if (cls[CLS_UNARY]) begin
                    Grb = 1'b1; Rout = 1'b1; ZLOin = 1'b1; alu_op = opcode;
                end
                if (cls[CLS_BR]) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end
                if (cls[CLS_MFHI]) begin
                    HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
                if (cls[CLS_MFLO]) begin
                    LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            ST_T4: begin
                if (cls[CLS_RR]) begin
                    Grc = 1'b1; Rout = 1'b1; ZLOin = 1'b1; alu_op = opcode;
                end
                if (cls[CLS_IMM]) begin
                    Cout = 1'b1; ZLOin = 1'b1; alu_op = opcode;
                end
                if (cls[CLS_LD] || cls[CLS_LDI] || cls[CLS_ST]) begin
                    Cout = 1'b1; ZLOin = 1'b1; alu_op = ALU_ADD;
                end
                if (cls[CLS_MULDIV]) begin
                    Grb = 1'b1; Rout = 1'b1; ZLOin = 1'b1; ZHIin = 1'b1;
                    alu_op = opcode;
                end
                if (cls[CLS_UNARY]) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
                if (cls[CLS_BR]) begin
                    PCout = 1'b1; Yin = 1'b1;
                end
            end
            ST_T5: begin
                if (cls[CLS_RR] || cls[CLS_IMM] || cls[CLS_LDI]) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
                if (cls[CLS_LD] || cls[CLS_ST]) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end
                if (cls[CLS_MULDIV]) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end
                if (cls[CLS_BR]) begin
                    Cout = 1'b1; ZLOin = 1'b1; alu_op = ALU_ADD;
                end
            end
            ST_T6: begin
                if (cls[CLS_LD]) begin
                    Read = 1'b1; MDRin = 1'b1;
                end
                // Store data goes onto the bus from the register file, not memory
                if (cls[CLS_ST]) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end
                if (cls[CLS_MULDIV]) begin
                    ZHighout = 1'b1; HIin = 1'b1;
                end
                // Branch target is committed only when the condition holds
                if (cls[CLS_BR]) begin
                    Zlowout = 1'b1; PCin = con_ff;
                end
            end
            ST_T7: begin
                if (cls[CLS_LD]) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
                if (cls[CLS_ST]) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: each instruction is turned into its expected
// per-cycle control-word sequence (fetch plus execute steps) and every cycle
// of the DUT is compared against it. Covers directed instructions, random
// opcodes, mid-instruction clear and halt.
module tb_control_sequencer;
    import cpu_defs::*;

    logic        clock;
    logic        clear;
    logic [31:0] ir;
    logic        con_ff;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic PCin, IRin, Yin, HIin, LOin, MARin, MDRin, ZHIin, ZLOin, CONin;
    logic PCout, MDRout, ZHighout, Zlowout, HIout, LOout, Cout;
    logic Read, Write, IncPC, run;
    logic [4:0] alu_op;
    logic [3:0] state_dbg;

    control_sequencer dut (
        .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCin(PCin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
        .MARin(MARin), .MDRin(MDRin), .ZHIin(ZHIin), .ZLOin(ZLOin), .CONin(CONin),
        .PCout(PCout), .MDRout(MDRout), .ZHighout(ZHighout), .Zlowout(Zlowout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout),
        .Read(Read), .Write(Write), .IncPC(IncPC),
        .alu_op(alu_op), .run(run), .state_dbg(state_dbg)
    );

    // Control word: bit per signal, alu_op on top
    localparam logic [31:0] B_GRA = 32'h1 << 0,  B_GRB = 32'h1 << 1,  B_GRC = 32'h1 << 2;
    localparam logic [31:0] B_RIN = 32'h1 << 3,  B_ROUT = 32'h1 << 4, B_BAOUT = 32'h1 << 5;
    localparam logic [31:0] B_PCIN = 32'h1 << 6, B_IRIN = 32'h1 << 7, B_YIN = 32'h1 << 8;
    localparam logic [31:0] B_HIIN = 32'h1 << 9, B_LOIN = 32'h1 << 10, B_MARIN = 32'h1 << 11;
    localparam logic [31:0] B_MDRIN = 32'h1 << 12, B_ZHIIN = 32'h1 << 13, B_ZLOIN = 32'h1 << 14;
    localparam logic [31:0] B_CONIN = 32'h1 << 15, B_PCOUT = 32'h1 << 16, B_MDROUT = 32'h1 << 17;
    localparam logic [31:0] B_ZHIGHOUT = 32'h1 << 18, B_ZLOWOUT = 32'h1 << 19;
    localparam logic [31:0] B_HIOUT = 32'h1 << 20, B_LOOUT = 32'h1 << 21, B_COUT = 32'h1 << 22;
    localparam logic [31:0] B_READ = 32'h1 << 23, B_WRITE = 32'h1 << 24, B_INCPC = 32'h1 << 25;
    localparam logic [31:0] B_RUN = 32'h1 << 26;

    logic [31:0] obs;
    assign obs = {alu_op, run, IncPC, Write, Read, Cout, LOout, HIout, Zlowout,
                  ZHighout, MDRout, PCout, CONin, ZLOin, ZHIin, MDRin, MARin,
                  LOin, HIin, Yin, IRin, PCin, BAout, Rout, Rin, Grc, Grb, Gra};

    logic [31:0] exp_q[$];
    int n_checks;
    int n_fail;
    int wr_glitch;
    logic mid_abort;

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Any Write edge inside the abort window is an escaped store
    always @(posedge Write) if (mid_abort) wr_glitch++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu(input logic [4:0] code);
        return {code, 27'd0};
    endfunction

    task automatic push(input logic [31:0] w);
        exp_q.push_back(w | B_RUN);
    endtask

    // Expected control words for one instruction, fetch included
    task automatic load_program(input logic [4:0] op, input logic c);
        push(B_PCOUT | B_MARIN | B_INCPC | B_ZLOIN);
        push(B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN);
        push(B_MDROUT | B_IRIN);
        case (op)
            5'b00011, 5'b00100, 5'b01001, 5'b01010: begin
                push(B_GRB | B_ROUT | B_YIN);
                push(B_GRC | B_ROUT | B_ZLOIN | alu(op));
                push(B_ZLOWOUT | B_GRA | B_RIN);
            end
            5'b01011, 5'b01100, 5'b01101: begin
                push(B_GRB | B_ROUT | B_YIN);
                push(B_COUT | B_ZLOIN | alu(op));
                push(B_ZLOWOUT | B_GRA | B_RIN);
            end
            5'b00000: begin
                push(B_GRB | B_BAOUT | B_YIN);
                push(B_COUT | B_ZLOIN | alu(5'b00011));
                push(B_ZLOWOUT | B_MARIN);
                push(B_READ | B_MDRIN);
                push(B_MDROUT | B_GRA | B_RIN);
            end
            5'b00001: begin
                push(B_GRB | B_BAOUT | B_YIN);
                push(B_COUT | B_ZLOIN | alu(5'b00011));
                push(B_ZLOWOUT | B_GRA | B_RIN);
            end
            5'b00010: begin
                push(B_GRB | B_BAOUT | B_YIN);
                push(B_COUT | B_ZLOIN | alu(5'b00011));
                push(B_ZLOWOUT | B_MARIN);
                push(B_GRA | B_ROUT | B_MDRIN);
                push(B_WRITE);
            end
            5'b01110, 5'b01111: begin
                push(B_GRA | B_ROUT | B_YIN);
                push(B_GRB | B_ROUT | B_ZLOIN | B_ZHIIN | alu(op));
                push(B_ZLOWOUT | B_LOIN);
                push(B_ZHIGHOUT | B_HIIN);
            end
            5'b10000, 5'b10001: begin
                push(B_GRB | B_ROUT | B_ZLOIN | alu(op));
                push(B_ZLOWOUT | B_GRA | B_RIN);
            end
            5'b10010: begin
                push(B_GRA | B_ROUT | B_CONIN);
                push(B_PCOUT | B_YIN);
                push(B_COUT | B_ZLOIN | alu(5'b00011));
                push(B_ZLOWOUT | (c ? B_PCIN : 32'h0));
            end
            5'b10111: push(B_HIOUT | B_GRA | B_RIN);
            5'b11000: push(B_LOOUT | B_GRA | B_RIN);
            default: ;  // nop, undefined and halt: fetch only
        endcase
    endtask

    // Drive one cycle of step k and compare it; caller is at posedge+1
    task automatic drive_step(input int k, input logic [31:0] instr, input logic c);
        ir     = (k < 2) ? $urandom() : instr;           // junk during early fetch
        con_ff = (k == 6) ? c : 1'($urandom_range(0, 1)); // only T6 may matter
        @(negedge clock);
        check($sformatf("op%b_step%0d", instr[31:27], k), obs, exp_q.pop_front());
        @(posedge clock); #1;
    endtask

    task automatic run_instr(input logic [31:0] instr, input logic c);
        int n;
        load_program(instr[31:27], c);
        n = exp_q.size();
        for (int k = 0; k < n; k++) drive_step(k, instr, c);
    endtask

    // Asynchronous clear mid-cycle, then release into T0
    task automatic do_reset();
        #2 clear = 1'b0;
        #1;
        check("clear_outputs", obs, 32'h0);
        check("clear_state", {28'd0, state_dbg}, {28'd0, ST_RST});
        repeat (2) @(posedge clock);
        #1 check("rst_hold", obs, 32'h0);
        @(negedge clock) clear = 1'b1;
        @(posedge clock); #1;
        exp_q.delete();
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] instr;
        n_checks = 0; n_fail = 0; wr_glitch = 0; mid_abort = 1'b0;
        clear = 1'b0; ir = 32'h0; con_ff = 1'b0;
        #1;
        check("reset_outputs", obs, 32'h0);
        check("reset_state", {28'd0, state_dbg}, {28'd0, ST_RST});
        @(posedge clock); #1;
        do_reset();

        // Directed: one of each class, both branch outcomes, undefined opcode
        run_instr(32'h18918000, 1'b0);               // add R1,R2,R3
        run_instr({5'b00000, 27'h0123456}, 1'b0);    // ld
        run_instr({5'b10010, 27'h0000042}, 1'b1);    // br taken
        run_instr({5'b10010, 27'h0000042}, 1'b0);    // br not taken
        run_instr({5'b00010, 27'h0ABCDEF}, 1'b1);    // st
        run_instr({5'b00001, 27'h0000007}, 1'b0);    // ldi
        run_instr({5'b01011, 27'h0000010}, 1'b0);    // addi
        run_instr({5'b01110, 27'h0000000}, 1'b0);    // mul
        run_instr({5'b10001, 27'h0000000}, 1'b0);    // not
        run_instr({5'b10111, 27'h0000000}, 1'b0);    // mfhi
        run_instr({5'b11000, 27'h0000000}, 1'b0);    // mflo
        run_instr({5'b11001, 27'h0000000}, 1'b0);    // nop
        run_instr({5'b11111, 27'h7FFFFFF}, 1'b1);    // undefined -> nop

        // Random opcodes (halt handled separately)
        for (int i = 0; i < 60; i++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11010) op = 5'b11001;
            instr = {op, 27'($urandom())};
            run_instr(instr, 1'($urandom_range(0, 1)));
        end

        // Clear during st T6: no Write may escape, restart at T0
        instr = {5'b00010, 27'h0000055};
        load_program(instr[31:27], 1'b0);
        for (int k = 0; k < 6; k++) drive_step(k, instr, 1'b0);
        #1 check("st_t6_before_clear", obs, exp_q.pop_front());
        mid_abort = 1'b1;
        do_reset();
        repeat (2) @(posedge clock);
        mid_abort = 1'b0;
        check("st_abort_no_write", wr_glitch, 32'd0);
        do_reset();
        run_instr(32'h18918000, 1'b0);

        // Halt: parks with everything low until clear
        instr = 32'hD0000000;
        load_program(instr[31:27], 1'b0);
        for (int k = 0; k < 3; k++) drive_step(k, instr, 1'b0);
        for (int k = 0; k < 20; k++) begin
            con_ff = 1'($urandom_range(0, 1));
            @(negedge clock);
            check("halt_outputs", obs, 32'h0);
            check("halt_state", {28'd0, state_dbg}, {28'd0, ST_HALT});
            @(posedge clock); #1;
        end
        do_reset();
        run_instr({5'b00011, 27'h0000000}, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
